// File: rtl/spi_slave_mode.sv
// spi_slave_mode: oversampled SPI slave with configurable width, CPOL/CPHA and bit order.
// Define SPI_SLAVE_MISO_EN to build the MISO transmit path (holding + shift register).
module spi_slave_mode #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic                  clk_in,
  input  logic                  spi_rst_n,
  input  logic                  spi_sclk_in,
  input  logic                  spi_mosi_in,
  input  logic                  spi_cs_n_in,
  output logic                  spi_miso_out,
  output logic                  rx_rdy_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_load_in,
  output logic                  tx_empty_out,
  output logic                  frame_err_out
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, sclk_d, cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic rx_rdy_q, rx_rdy_d, frame_err_q, frame_err_d;
  logic rise, fall, lead, trail, sample, shift, cs_fall, cs_rise, xfer, last;
  always_comb begin
    sclk_d = {sclk_q[1:0], spi_sclk_in};
    cs_d = {cs_q[1:0], spi_cs_n_in};
    mosi_d = {mosi_q[0], spi_mosi_in};
    rise = sclk_q[1] & ~sclk_q[2];
    fall = ~sclk_q[1] & sclk_q[2];
    lead = (CPOL != 0) ? fall : rise;
    trail = (CPOL != 0) ? rise : fall;
    sample = (CPHA != 0) ? trail : lead;
    shift = (CPHA != 0) ? lead : trail;
    cs_fall = ~cs_q[1] & cs_q[2];
    cs_rise = cs_q[1] & ~cs_q[2];
    xfer = state_q == XFER && !cs_rise;
    last = cnt_q == LAST;
    state_d = (state_q == IDLE) ? (cs_fall ? XFER : IDLE) : (cs_rise ? IDLE : XFER);
    frame_err_d = state_q == XFER && cs_rise && cnt_q != '0;
    rx_sh_d = !(xfer && sample) ? rx_sh_q :
              (LSB_FIRST != 0) ? {mosi_q[1], rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], mosi_q[1]};
    rx_rdy_d = xfer && sample && last;
    rx_data_d = rx_rdy_d ? rx_sh_d : rx_data_q;
    cnt_d = !xfer ? '0 : !sample ? cnt_q : last ? '0 : cnt_q + 1'b1;
  end
`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d, tx_sh_q, tx_sh_d;
  logic full_q, full_d, miso_q, miso_d, boundary;
  // a load coinciding with a boundary still moves the old holding word out
  always_comb begin
    boundary = (xfer && shift && cnt_q == '0) || (CPHA == 0 && state_q == IDLE && cs_fall);
    tx_sh_d = boundary ? (full_q ? hold_q : '0) :
              (state_q == XFER && cs_rise) ? '0 :
              (xfer && shift) ? ((LSB_FIRST != 0) ? tx_sh_q >> 1 : tx_sh_q << 1) : tx_sh_q;
    full_d = tx_load_in | (full_q & ~boundary);
    hold_d = tx_load_in ? tx_data_in : hold_q;
    miso_d = state_d == XFER && ((LSB_FIRST != 0) ? tx_sh_d[0] : tx_sh_d[DATA_WIDTH-1]);
  end
  assign spi_miso_out = miso_q;
  assign tx_empty_out = ~full_q;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data_in, tx_load_in};
  assign spi_miso_out = 1'b0;
  assign tx_empty_out = 1'b1;
`endif
  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state_q <= IDLE;
      sclk_q <= (CPOL != 0) ? 3'b111 : 3'b000;
      cs_q <= 3'b111;
      mosi_q <= '0;
      cnt_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_rdy_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      hold_q <= '0;
      tx_sh_q <= '0;
      full_q <= 1'b0;
      miso_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
      cnt_q <= cnt_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_rdy_q <= rx_rdy_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_SLAVE_MISO_EN
      hold_q <= hold_d;
      tx_sh_q <= tx_sh_d;
      full_q <= full_d;
      miso_q <= miso_d;
`endif
    end
  end
  assign rx_rdy_out = rx_rdy_q;
  assign rx_data_out = rx_data_q;
  assign frame_err_out = frame_err_q;
endmodule

// File: tb/tb_spi_slave_mode.sv
// tb_spi_slave_mode: bench-driven SPI master on three slave configurations
// (mode 0/8b/MSB, mode 1/8b/MSB, mode 3/16b/LSB) checked against word-level expectations.
module tb_spi_slave_mode;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic spi_rst_n;
  logic sclk [3], mosi [3], cs_n [3], miso [3], rdy [3], txe [3], ferr [3], load [3];
  logic [7:0] rxd0, rxd1, txd0, txd1;
  logic [15:0] rxd2, txd2;
  int checks = 0, errors = 0;
  logic [31:0] exp_rx [3][$];
  int ferr_pend [3];
  logic prdy [3], pferr [3];
  logic [31:0] wv [3], tv [3], d1, d2;
  int h1 = -1, h2 = -1;
  bit started = 0;

  spi_slave_mode #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u0 (
    .clk_in(clk_in), .spi_rst_n(spi_rst_n), .spi_sclk_in(sclk[0]), .spi_mosi_in(mosi[0]),
    .spi_cs_n_in(cs_n[0]), .spi_miso_out(miso[0]), .rx_rdy_out(rdy[0]), .rx_data_out(rxd0),
    .tx_data_in(txd0), .tx_load_in(load[0]), .tx_empty_out(txe[0]), .frame_err_out(ferr[0]));
  spi_slave_mode #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .LSB_FIRST(0)) u1 (
    .clk_in(clk_in), .spi_rst_n(spi_rst_n), .spi_sclk_in(sclk[1]), .spi_mosi_in(mosi[1]),
    .spi_cs_n_in(cs_n[1]), .spi_miso_out(miso[1]), .rx_rdy_out(rdy[1]), .rx_data_out(rxd1),
    .tx_data_in(txd1), .tx_load_in(load[1]), .tx_empty_out(txe[1]), .frame_err_out(ferr[1]));
  spi_slave_mode #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u2 (
    .clk_in(clk_in), .spi_rst_n(spi_rst_n), .spi_sclk_in(sclk[2]), .spi_mosi_in(mosi[2]),
    .spi_cs_n_in(cs_n[2]), .spi_miso_out(miso[2]), .rx_rdy_out(rdy[2]), .rx_data_out(rxd2),
    .tx_data_in(txd2), .tx_load_in(load[2]), .tx_empty_out(txe[2]), .frame_err_out(ferr[2]));

  function automatic int wid(input int i); return (i == 2) ? 16 : 8; endfunction
  function automatic int cpol(input int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int cpha(input int i); return (i == 0) ? 0 : 1; endfunction
  function automatic int lsb(input int i); return (i == 2) ? 1 : 0; endfunction
  function automatic logic [31:0] rxv(input int i);
    return (i == 0) ? {24'h0, rxd0} : (i == 1) ? {24'h0, rxd1} : {16'h0, rxd2};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic load_pulse(input int i, input logic [31:0] v);
    if (i == 0) txd0 = v[7:0];
    else if (i == 1) txd1 = v[7:0];
    else txd2 = v[15:0];
    load[i] = 1'b1;
    @(negedge clk_in);
    load[i] = 1'b0;
  endtask

  // leading edge; a hooked edge loads TX exactly on the cycle its strobe takes effect
  task automatic lead(input int i, input int t);
    sclk[i] = (cpol(i) == 0);
    if (t == h1 || t == h2) begin
      repeat (2) @(negedge clk_in);
      load_pulse(i, (t == h1) ? d1 : d2);
`ifdef SPI_SLAVE_MISO_EN
      chk("tx_empty_after_load", {31'h0, txe[i]}, 32'h0);
`endif
      repeat (5) @(negedge clk_in);
    end else repeat (8) @(negedge clk_in);
  endtask

  task automatic bit_cycle(input int i, input logic bv, input int t, output logic sb);
    mosi[i] = bv;
    if (cpha(i) == 0) begin
      repeat (8) @(negedge clk_in);
      sb = miso[i];
      lead(i, t);
      sclk[i] = (cpol(i) != 0);
    end else begin
      lead(i, t);
      sb = miso[i];
      sclk[i] = (cpol(i) != 0);
      repeat (8) @(negedge clk_in);
    end
  endtask

  task automatic xfer(input int i, input int nw, input int abort_bits);
    int w, t, done, pos;
    bit ab;
    logic sb;
    logic [31:0] got, mask;
    logic [31:0] gotw [3];
    w = wid(i);
    mask = (32'h1 << w) - 1;
    t = 0;
    done = 0;
    ab = 0;
    cs_n[i] = 1'b0;
    repeat (16) @(negedge clk_in);
    for (int k = 0; k < nw && !ab; k++) begin
      got = 0;
      for (int b = 0; b < w && !ab; b++) begin
        pos = (lsb(i) != 0) ? b : w - 1 - b;
        if (t == abort_bits) ab = 1;
        else begin
          if (b == w - 1) exp_rx[i].push_back(wv[k] & mask);
          bit_cycle(i, wv[k][pos], t, sb);
          got[pos] = sb;
          t++;
        end
      end
      if (!ab) begin
        gotw[done] = got;
        done++;
      end
    end
    if (ab) ferr_pend[i]++;
    repeat (8) @(negedge clk_in);
    cs_n[i] = 1'b1;
    repeat (16) @(negedge clk_in);
`ifdef SPI_SLAVE_MISO_EN
    for (int k = 0; k < done; k++) chk("miso_word", gotw[k], tv[k] & mask);
    chk("miso_idle", {31'h0, miso[i]}, 32'h0);
    chk("tx_empty_end", {31'h0, txe[i]}, 32'h1);
`endif
  endtask

  // scoreboard: every rx_rdy / frame_err pulse must match a pending expectation
  always @(negedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (started && spi_rst_n) begin
        if (rdy[i]) begin
          chk("rx_rdy_width", {31'h0, prdy[i]}, 32'h0);
          if (exp_rx[i].size() == 0) chk("rx_unexpected", {31'h0, rdy[i]}, 32'h0);
          else chk("rx_data", rxv(i), exp_rx[i].pop_front());
        end
        if (ferr[i]) begin
          chk("frame_err_width", {31'h0, pferr[i]}, 32'h0);
          if (ferr_pend[i] == 0) chk("frame_err_unexpected", {31'h0, ferr[i]}, 32'h0);
          else ferr_pend[i]--;
        end
`ifndef SPI_SLAVE_MISO_EN
        chk("miso_const", {31'h0, miso[i]}, 32'h0);
        chk("tx_empty_const", {31'h0, txe[i]}, 32'h1);
`endif
      end
      prdy[i] = rdy[i];
      pferr[i] = ferr[i];
    end
  end

  task automatic reset_checks(input int i);
    chk("rst_rx_rdy", {31'h0, rdy[i]}, 32'h0);
    chk("rst_rx_data", rxv(i), 32'h0);
    chk("rst_miso", {31'h0, miso[i]}, 32'h0);
    chk("rst_tx_empty", {31'h0, txe[i]}, 32'h1);
    chk("rst_frame_err", {31'h0, ferr[i]}, 32'h0);
  endtask

  task automatic set_words(input logic [31:0] a, b, c, input logic [31:0] ta, tb, tc);
    wv[0] = a; wv[1] = b; wv[2] = c;
    tv[0] = ta; tv[1] = tb; tv[2] = tc;
  endtask

  initial begin
    logic sb;
    spi_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sclk[i] = (cpol(i) != 0);
      cs_n[i] = 1'b1;
      mosi[i] = 1'b0;
      load[i] = 1'b0;
      ferr_pend[i] = 0;
      prdy[i] = 1'b0;
      pferr[i] = 1'b0;
    end
    txd0 = 0; txd1 = 0; txd2 = 0; d1 = 0; d2 = 0;
    repeat (3) @(negedge clk_in);
    spi_rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 3; i++) reset_checks(i);
    started = 1;
    // mode 0: two words in one frame, preloaded TX then empty holding
    load_pulse(0, 32'h96);
    set_words(32'hA5, 32'h3C, 0, 32'h96, 32'h00, 0);
    xfer(0, 2, -1);
    chk("mode0_last_word", {24'h0, rxd0}, 32'h3C);
    // mode 3, 16 bit, LSB first
    set_words(32'h1234, 0, 0, 0, 0, 0);
    xfer(2, 1, -1);
    chk("mode3_word", {16'h0, rxd2}, 32'h1234);
    // mode 1: overwrite while full, reload during word 1, third word empty
    load_pulse(1, 32'h99);
    load_pulse(1, 32'hC3);
`ifdef SPI_SLAVE_MISO_EN
    chk("tx_empty_loaded", {31'h0, txe[1]}, 32'h0);
`endif
    h1 = 3; d1 = 32'h5A;
    set_words(32'h11, 32'h22, 32'h33, 32'hC3, 32'h5A, 32'h00);
    xfer(1, 3, -1);
    h1 = -1;
    // abort after 5 bits, then a clean frame
    set_words(32'hFF, 0, 0, 0, 0, 0);
    xfer(0, 1, 5);
    set_words(32'h81, 0, 0, 0, 0, 0);
    xfer(0, 1, -1);
    chk("after_abort_word", {24'h0, rxd0}, 32'h81);
    // asynchronous reset after 3 bits of a word
    cs_n[0] = 1'b0;
    repeat (16) @(negedge clk_in);
    for (int b = 0; b < 3; b++) bit_cycle(0, b[0], 100, sb);
    spi_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) reset_checks(i);
    repeat (2) @(negedge clk_in);
    spi_rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    cs_n[0] = 1'b1;
    repeat (16) @(negedge clk_in);
    set_words(32'h7E, 0, 0, 0, 0, 0);
    xfer(0, 1, -1);
    chk("after_reset_word", {24'h0, rxd0}, 32'h7E);
    // load exactly on the word-2 boundary transfer cycle
    load_pulse(1, 32'h11);
    h1 = 3; d1 = 32'h22; h2 = 8; d2 = 32'h77;
    set_words(32'hA1, 32'hB2, 32'hC3, 32'h11, 32'h22, 32'h77);
    xfer(1, 3, -1);
    h1 = -1; h2 = -1;
    for (int r = 0; r < 12; r++) begin
      int ii, nw, ab;
      logic [31:0] v;
      ii = $urandom_range(0, 2);
      nw = $urandom_range(1, 3);
      ab = -1;
      if ($urandom_range(0, 3) == 0) begin
        nw = 1;
        ab = $urandom_range(1, wid(ii) - 1);
      end
      for (int k = 0; k < 3; k++) begin
        wv[k] = $urandom;
        tv[k] = 0;
      end
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        load_pulse(ii, v);
        tv[0] = v;
      end
      xfer(ii, nw, ab);
    end
    repeat (20) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      chk("rx_pending", exp_rx[i].size(), 32'h0);
      chk("frame_err_pending", ferr_pend[i], 32'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
